// File: rtl/scoreboard_stall_unit_if.sv
// Decode/execute/writeback hazard signals exchanged between the core pipeline
// and the stall/flush controller.
interface scoreboard_stall_unit_if;
  logic [4:0]  RS1D;
  logic [4:0]  RS2D;
  logic [4:0]  RDD;
  logic        RegWriteD;
  logic        LongD;
  logic [4:0]  RDE;
  logic        ResultSrcE0;
  logic        IssueLongE;
  logic        PCSrcE;
  logic        LongDoneW;
  logic [4:0]  LongRDW;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        FlushE;
  logic        Full;
  logic        ErrSticky;
  logic [15:0] StallCount;

  modport master (
    output RS1D, RS2D, RDD, RegWriteD, LongD, RDE, ResultSrcE0,
           IssueLongE, PCSrcE, LongDoneW, LongRDW,
    input  StallF, StallD, FlushD, FlushE, Full, ErrSticky, StallCount
  );

  modport slave (
    input  RS1D, RS2D, RDD, RegWriteD, LongD, RDE, ResultSrcE0,
           IssueLongE, PCSrcE, LongDoneW, LongRDW,
    output StallF, StallD, FlushD, FlushE, Full, ErrSticky, StallCount
  );
endinterface

// File: rtl/scoreboard_stall_unit.sv
// Decode-side stall/flush controller: load-use, long-latency busy scoreboard,
// WAW on pending destinations, issue capacity and taken-branch flushes.
module scoreboard_stall_unit #(
  parameter int unsigned MAX_PENDING = 4
) (
  input logic              clk,
  input logic              rst,
  scoreboard_stall_unit_if.slave sif
);
  localparam logic [2:0] CAP    = 3'(MAX_PENDING);
  localparam logic [2:0] CAP_M1 = 3'(MAX_PENDING - 1);

  logic [31:0] busy, busy_clr, busy_next;
  logic [2:0]  count, count_next;
  logic        err;
  logic [15:0] stall_cnt;

  logic full, clr_ok, set_ok, bad_done, bad_issue;
  logic lduse, inflight, sbraw, sbwaw, cap, stall;
  logic stall_f, stall_d, flush_d, flush_e;

  // Clear is resolved before set so a same-register complete+reissue keeps busy.
  always_comb begin
    full     = (count == CAP);
    clr_ok   = sif.LongDoneW && (sif.LongRDW != '0) && busy[sif.LongRDW];
    bad_done = sif.LongDoneW && (sif.LongRDW != '0) && !busy[sif.LongRDW];
    busy_clr = busy;
    if (clr_ok) busy_clr[sif.LongRDW] = 1'b0;
    set_ok    = sif.IssueLongE && (sif.RDE != '0) && !busy_clr[sif.RDE] && !full;
    bad_issue = sif.IssueLongE && (full || ((sif.RDE != '0) && busy_clr[sif.RDE]));
    busy_next = busy_clr;
    if (set_ok) busy_next[sif.RDE] = 1'b1;
    busy_next[0] = 1'b0;
    count_next = count + {2'b00, set_ok} - {2'b00, clr_ok};
  end

  always_comb begin
    lduse    = sif.ResultSrcE0 && (sif.RDE != '0) &&
               ((sif.RDE == sif.RS1D) || (sif.RDE == sif.RS2D));
    inflight = sif.IssueLongE && (sif.RDE != '0) &&
               ((sif.RDE == sif.RS1D) || (sif.RDE == sif.RS2D) ||
                (sif.RegWriteD && (sif.RDE == sif.RDD)));
    sbraw    = busy[sif.RS1D] || busy[sif.RS2D];
    sbwaw    = sif.RegWriteD && busy[sif.RDD];
    cap      = sif.LongD && (full || ((count == CAP_M1) && sif.IssueLongE));
    stall    = lduse || inflight || sbraw || sbwaw || cap;
  end

  // Branch flush takes priority over any stall; everything is held low in reset.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (!rst) begin
      if (sif.PCSrcE) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        stall_f = stall;
        stall_d = stall;
        flush_e = stall;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= '0;
      count     <= '0;
      err       <= 1'b0;
      stall_cnt <= '0;
    end else begin
      busy  <= busy_next;
      count <= count_next;
      if (bad_done || bad_issue) err <= 1'b1;
      if (stall_d && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign sif.StallF     = stall_f;
  assign sif.StallD     = stall_d;
  assign sif.FlushD     = flush_d;
  assign sif.FlushE     = flush_e;
  assign sif.Full       = full;
  assign sif.ErrSticky  = err;
  assign sif.StallCount = stall_cnt;
endmodule

// File: doc/scoreboard_stall_unit.md
# scoreboard_stall_unit

Pipeline stall/flush controller for the five-stage core: the decode-side counterpart to the execute-stage forwarding logic. Forwarding resolves single-cycle RAW hazards. This block covers the cases it cannot: load-use hazards, long-latency (multi-cycle divide) results tracked in a 32-entry busy scoreboard, WAW on pending destinations, and taken-branch flushes. It drives StallF/StallD/FlushD/FlushE to the pipeline registers.

## Interface
- MAX_PENDING, 4: maximum long-latency ops in flight (1..7).
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- RS1D, RS2D  in  5  source registers of instruction in decode.
- RDD  in  5  destination of instruction in decode.
- RegWriteD  in  1  decode instruction writes RDD.
- LongD  in  1  decode instruction is a long-latency op.
- RDE  in  5  destination of instruction in execute.
- ResultSrcE0  in  1  execute instruction is a load.
- IssueLongE  in  1  long-latency op leaving execute this cycle (dest RDE).
- PCSrcE  in  1  taken branch/jump resolved in execute.
- LongDoneW  in  1  long-latency result written back this cycle.
- LongRDW  in  5  destination of completing long op.
- StallF, StallD  out  1  hold PC / IF-ID register.
- FlushD, FlushE  out  1  clear IF-ID / ID-EX register.
- Full  out  1  pending count == MAX_PENDING.
- ErrSticky  out  1  protocol violation seen since reset.
- StallCount  out  16  saturating count of stall cycles.

## Operation
- State: busy[31:0], pending counter (3 bits), ErrSticky, StallCount. busy[0] never set.
- Set: IssueLongE && RDE!=0 && !busy[RDE] && !Full → busy[RDE]<=1, count+1.
- Clear: LongDoneW && LongRDW!=0 && busy[LongRDW] → busy[LongRDW]<=0, count-1.
- Set and clear in the same cycle on different regs: count unchanged. Same reg: clear applied first, then set (busy stays 1, count unchanged).
- Violations set ErrSticky; the offending op changes no state:
  - LongDoneW on a non-busy reg (non-zero LongRDW).
  - IssueLongE while Full.
  - IssueLongE to an already-busy reg.
- Hazard terms (combinational; addresses of x0 never match):
  - lduse = ResultSrcE0 && RDE!=0 && (RDE==RS1D || RDE==RS2D).
  - inflight = IssueLongE && RDE!=0 && (RDE==RS1D || RDE==RS2D || (RegWriteD && RDE==RDD)).
  - sbraw = busy[RS1D] || busy[RS2D].
  - sbwaw = RegWriteD && busy[RDD].
  - cap = LongD && (Full || (count==MAX_PENDING-1 && IssueLongE)).
  - stall = lduse | inflight | sbraw | sbwaw | cap.
- Outputs:
  - PCSrcE=1: FlushD=1, FlushE=1, StallF=StallD=0. Branch wins over stall.
  - Else: StallF=StallD=FlushE=stall, FlushD=0.
- A same-cycle clear does not release a stall. Release is visible the cycle after busy drops.
- StallCount increments each cycle StallD=1 and saturates at 0xFFFF.

## Timing
- rst high (async): busy=0, count=0, ErrSticky=0, StallCount=0. All stall/flush outputs forced 0 while rst is high. Full=0.
- Outputs are combinational from current state and inputs. State updates at posedge clk.
- Issue → busy visible: 1 cycle. The inflight term covers the issue cycle.
- Writeback → stall release: 1 cycle after LongDoneW.
- Load-use: exactly one stall cycle per load-use pair, with FlushE inserting a bubble.
- Reset mid-operation clears all pending state immediately. No completion is expected afterwards.

## Test plan
- Load-use: ResultSrcE0=1, RDE=5, RS1D=5 → StallF=StallD=FlushE=1 for one cycle. With RDE=0 → no stall.
- Long op: IssueLongE, RDE=7; dependent RS2D=7 held in decode → stalled from the issue cycle. LongDoneW, LongRDW=7 at cycle N → StallD=0 at N+1.
- WAW: busy[9]=1, RegWriteD=1, RDD=9, RS1D=RS2D=0 → stall until reg 9 clears.
- Capacity: MAX_PENDING=4, four issues to regs 1..4 → Full=1. LongD=1 stalls. A fifth IssueLongE sets ErrSticky=1 and count stays 4.
- Branch priority: PCSrcE=1 during a load-use stall → FlushD=FlushE=1, StallF=StallD=0.
- Reset: rst pulsed mid-op with busy[3]=1 and StallCount=20 → busy=0, StallCount=0, all outputs 0 asynchronously. A later LongDoneW to reg 3 sets ErrSticky.
